// File: rtl/egress_port_arbiter.sv
// egress_port_arbiter
//   Per-egress-port packet scheduler. Shares one TX channel between the
//   ingress ports requesting it. Round-robin arbitration with packet
//   granularity: a granted port owns the channel until its end-of-packet beat.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     Enables a stall watchdog. After TIMEOUT_CYCLES consecutive XFER cycles
//     without a transferred beat, the grant is revoked and abort_o pulses.
//
//   Ports
//     clk, rst_n            clock, synchronous active-low reset
//     req_i                 per-port: complete packet queued for this egress
//     valid_i / eop_i       per-port beat valid / last beat of packet
//     data_i / ctrl_i       concatenated per-port beat data / control
//     ready_o               per-port beat accepted
//     grant_o               one-hot current owner (registered)
//     abort_o               one-cycle drop-packet pulse (registered)
//     tx_data_o, tx_ctrl_o  muxed beat towards the TX MAC
//     tx_valid_o, tx_eop_o  muxed beat valid / last beat
//     tx_ready_i            TX MAC accepts beat
//     busy_o                arbiter is not idle
module egress_port_arbiter #(
    parameter int unsigned NUM_OF_PORTS       = 4,
    parameter int unsigned RXTX_DATA_SIZE     = 32,
    parameter int unsigned RXTXCTRL_BITS_SIZE = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_OF_PORTS-1:0]                    req_i,
    input  logic [NUM_OF_PORTS-1:0]                    valid_i,
    input  logic [NUM_OF_PORTS-1:0]                    eop_i,
    input  logic [NUM_OF_PORTS*RXTX_DATA_SIZE-1:0]     data_i,
    input  logic [NUM_OF_PORTS*RXTXCTRL_BITS_SIZE-1:0] ctrl_i,
    output logic [NUM_OF_PORTS-1:0]                    ready_o,
    output logic [NUM_OF_PORTS-1:0]                    grant_o,
    output logic [NUM_OF_PORTS-1:0]                    abort_o,
    output logic [RXTX_DATA_SIZE-1:0]                  tx_data_o,
    output logic [RXTXCTRL_BITS_SIZE-1:0]              tx_ctrl_o,
    output logic                                       tx_valid_o,
    output logic                                       tx_eop_o,
    input  logic                                       tx_ready_i,
    output logic                                       busy_o
);

    localparam int unsigned IW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_XFER,
        S_RELEASE
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           last_q;
    logic [IW-1:0]           gidx_q;
    logic [NUM_OF_PORTS-1:0] grant_q;

    logic [RXTX_DATA_SIZE-1:0]     data_arr [NUM_OF_PORTS];
    logic [RXTXCTRL_BITS_SIZE-1:0] ctrl_arr [NUM_OF_PORTS];

    for (genvar i = 0; i < NUM_OF_PORTS; i++) begin : g_unpack
        assign data_arr[i] = data_i[i*RXTX_DATA_SIZE +: RXTX_DATA_SIZE];
        assign ctrl_arr[i] = ctrl_i[i*RXTXCTRL_BITS_SIZE +: RXTXCTRL_BITS_SIZE];
    end

    logic                    xfer;
    logic                    beat_fire;
    logic                    last_beat;
    logic                    win_found;
    logic [IW-1:0]           win_idx;
    logic [NUM_OF_PORTS-1:0] win_oh;
    int unsigned             cand;
    logic [IW-1:0]           cand_idx;

    assign xfer      = (state_q == S_XFER);
    assign beat_fire = xfer && valid_i[gidx_q] && tx_ready_i;
    assign last_beat = beat_fire && eop_i[gidx_q];
    assign busy_o    = (state_q != S_IDLE);
    assign grant_o   = grant_q;

    // Round-robin search starting one past the last owner, wrapping at the top.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NUM_OF_PORTS; k++) begin
            cand     = (32'(last_q) + k) % NUM_OF_PORTS;
            cand_idx = IW'(cand);
            if (!win_found && req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    // Zero-latency datapath from the owner; outputs are forced to 0 outside XFER
    // so tx_data_o/tx_ctrl_o never carry X after reset.
    always_comb begin
        ready_o    = '0;
        tx_valid_o = 1'b0;
        tx_eop_o   = 1'b0;
        tx_data_o  = '0;
        tx_ctrl_o  = '0;
        if (xfer) begin
            ready_o[gidx_q] = tx_ready_i;
            tx_valid_o      = valid_i[gidx_q];
            tx_eop_o        = eop_i[gidx_q];
            tx_data_o       = data_arr[gidx_q];
            tx_ctrl_o       = ctrl_arr[gidx_q];
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]           cnt_q;
    logic [NUM_OF_PORTS-1:0] abort_q;

    assign abort_o = abort_q;
`else
    assign abort_o = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NUM_OF_PORTS - 1);
            gidx_q  <= '0;
            grant_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            abort_q <= '0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            abort_q <= '0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        gidx_q  <= win_idx;
                        grant_q <= win_oh;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
`ifdef ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= S_XFER;
                end
                S_XFER: begin
                    if (last_beat) begin
                        last_q  <= gidx_q;
                        grant_q <= '0;
                        state_q <= S_RELEASE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (beat_fire) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        // This stalled cycle makes the count reach the limit:
                        // abort lands in the RELEASE cycle.
                        abort_q <= grant_q;
                        last_q  <= gidx_q;
                        grant_q <= '0;
                        state_q <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                S_RELEASE: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_egress_port_arbiter.sv
module tb_egress_port_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_i, valid_i, eop_i;
    logic [127:0] data_i;
    logic [15:0]  ctrl_i;
    logic [3:0]   ready_o, grant_o, abort_o;
    logic [31:0]  tx_data_o;
    logic [3:0]   tx_ctrl_o;
    logic         tx_valid_o, tx_eop_o, tx_ready_i, busy_o;

    egress_port_arbiter #(
        .NUM_OF_PORTS      (4),
        .RXTX_DATA_SIZE    (32),
        .RXTXCTRL_BITS_SIZE(4),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .valid_i   (valid_i),
        .eop_i     (eop_i),
        .data_i    (data_i),
        .ctrl_i    (ctrl_i),
        .ready_o   (ready_o),
        .grant_o   (grant_o),
        .abort_o   (abort_o),
        .tx_data_o (tx_data_o),
        .tx_ctrl_o (tx_ctrl_o),
        .tx_valid_o(tx_valid_o),
        .tx_eop_o  (tx_eop_o),
        .tx_ready_i(tx_ready_i),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  ctrl;
        logic        eop;
    } beat_t;

    typedef struct {
        int port;
        int gap;
    } gnt_t;

    typedef struct {
        logic [3:0] req;
        int         exp_port;
    } vec_t;

    beat_t src_q [4][$];
    beat_t exp_q [4][$];
    gnt_t  glog [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nbeats = 0;
    int last_eop_cyc = -100;
    int last_fire_cyc = -100;
    int abort_cnt = 0;
    int abort_gap = 0;
    logic [3:0] abort_val = '0;
    int seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pkt(input int p, input int n, input bit with_eop);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = {8'(p), 8'(seq), 16'($urandom)};
            b.ctrl = 4'($urandom);
            b.eop  = with_eop && (k == n - 1);
            seq++;
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    task automatic wait_idle(input int limit, output int at_cyc);
        bit done = 0;
        at_cyc = -1;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                done   = 1;
                at_cyc = cyc;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy_o still 1 after %0d cycles, required 0", limit);
        end
    endtask

    task automatic wait_grants(input int n, input int limit);
        for (int i = 0; i < limit && glog.size() < n; i++) @(negedge clk);
        if (glog.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_grants: got %0d grants, required %0d", glog.size(), n);
        end
    endtask

    // Reset for exactly one clock edge; sources and scoreboard flushed with it.
    task automatic reset_flush();
        rst_n      = 1'b0;
        req_i      = '0;
        tx_ready_i = 1'b0;
        tick();
        for (int p = 0; p < 4; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        glog.delete();
        @(negedge clk);
        chk("rst_grant", grant_o, 4'b0000);
        chk("rst_ready", ready_o, 4'b0000);
        chk("rst_abort", abort_o, 4'b0000);
        chk("rst_tx_valid", tx_valid_o, 1'b0);
        chk("rst_tx_eop", tx_eop_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_data_known", $isunknown({tx_data_o, tx_ctrl_o}), 1'b0);
        rst_n      = 1'b1;
        tx_ready_i = 1'b1;
        tick();
    endtask

    // Monitor + source model: scoreboard compare at negedge, source pops and
    // new beats applied just after the posedge.
    initial begin : mon
        beat_t        b;
        int           gport;
        logic         fire;
        logic [3:0]   pop_m, prev_grant, v, e;
        logic [127:0] d;
        logic [15:0]  c;
        valid_i = '0; eop_i = '0; data_i = '0; ctrl_i = '0; prev_grant = '0;
        forever begin
            @(negedge clk);
            gport = -1;
            for (int p = 0; p < 4; p++) if (grant_o[p]) gport = p;
            fire = tx_valid_o && tx_ready_i;
            if (fire) begin
                if (gport < 0 || exp_q[gport].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got beat %h with grant %b, required no transfer",
                             tx_data_o, grant_o);
                end else begin
                    b = exp_q[gport].pop_front();
                    chk("beat_data", tx_data_o, b.data);
                    chk("beat_ctrl", tx_ctrl_o, b.ctrl);
                    chk("beat_eop", tx_eop_o, b.eop);
                end
                nbeats++;
                last_fire_cyc = cyc;
                if (tx_eop_o) last_eop_cyc = cyc;
            end
            chk("ready_outside_grant", ready_o & ~grant_o, 4'b0000);
            if (grant_o != 0 && prev_grant == 0) glog.push_back('{gport, cyc - last_eop_cyc});
            prev_grant = grant_o;
            if (abort_o != 0) begin
                abort_cnt++;
                abort_val = abort_o;
                abort_gap = cyc - last_fire_cyc;
            end
            pop_m = ready_o & valid_i;
            @(posedge clk);
            cyc++;
            #2;
            v = '0; e = '0; d = '0; c = '0;
            for (int p = 0; p < 4; p++) begin
                if (pop_m[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
                if (src_q[p].size() != 0) begin
                    b = src_q[p][0];
                    v[p] = 1'b1;
                    e[p] = b.eop;
                    d[p*32 +: 32] = b.data;
                    c[p*4 +: 4] = b.ctrl;
                end
            end
            valid_i = v; eop_i = e; data_i = d; ctrl_i = c;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t  tbl [12];
        beat_t b;
        int    ic, nb0;

        tbl[0]  = '{4'b0001, 0};
        tbl[1]  = '{4'b1111, 1};
        tbl[2]  = '{4'b0101, 2};
        tbl[3]  = '{4'b0011, 0};
        tbl[4]  = '{4'b1000, 3};
        tbl[5]  = '{4'b1001, 0};
        tbl[6]  = '{4'b0110, 1};
        tbl[7]  = '{4'b1001, 3};
        tbl[8]  = '{4'b0100, 2};
        tbl[9]  = '{4'b1110, 3};
        tbl[10] = '{4'b0111, 0};
        tbl[11] = '{4'b0010, 1};

        rst_n = 1'b0; req_i = '0; tx_ready_i = 1'b0;
        tick(); tick();
        reset_flush();

        // Single 4-beat packet on port 0
        tick();
        load_pkt(0, 4, 1);
        req_i = 4'b0001;
        nb0 = nbeats;
        @(negedge clk);
        chk("t1_no_grant_yet", grant_o, 4'b0000);
        @(negedge clk);
        chk("t1_grant", grant_o, 4'b0001);
        chk("t1_grant_busy", busy_o, 1'b1);
        chk("t1_grant_cycle_no_tx", tx_valid_o, 1'b0);
        req_i = '0;
        @(negedge clk);
        chk("t1_first_beat_valid", tx_valid_o, 1'b1);
        wait_idle(30, ic);
        chk("t1_busy_low_after_eop", ic - last_eop_cyc, 2);
        chk("t1_beats", nbeats - nb0, 4);

        // Arbitration vectors from reset (last owner = port 3)
        reset_flush();
        for (int i = 0; i < 12; i++) begin
            tick();
            for (int p = 0; p < 4; p++)
                if (tbl[i].req[p] && src_q[p].size() == 0) load_pkt(p, 1, 1);
            req_i = tbl[i].req;
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), grant_o, 4'b0001 << tbl[i].exp_port);
            req_i = '0;
            wait_idle(20, ic);
        end

        // All ports requesting, 2-beat packets: order 0,1,2,3,0 with 3-cycle gaps
        reset_flush();
        load_pkt(0, 2, 1); load_pkt(1, 2, 1); load_pkt(2, 2, 1); load_pkt(3, 2, 1);
        load_pkt(0, 2, 1);
        req_i = 4'b1111;
        wait_grants(5, 200);
        req_i = '0;
        wait_idle(30, ic);
        if (glog.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t2_order%0d", i), glog[i].port, (i == 4) ? 0 : i);
                if (i > 0) chk($sformatf("t2_gap%0d", i), glog[i].gap, 3);
            end
        end
        for (int p = 0; p < 4; p++) chk("t2_all_sent", exp_q[p].size(), 0);

        // Port 2 packet with a 5-cycle TX stall in the middle
        reset_flush();
        load_pkt(2, 6, 1);
        req_i = 4'b0100;
        nb0 = nbeats;
        @(negedge clk);
        @(negedge clk);
        chk("t3_grant", grant_o, 4'b0100);
        req_i = '0;
        tick(); tick(); tick();
        tx_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", ready_o[2], 1'b0);
            chk("t3_stall_valid", tx_valid_o, 1'b1);
            if (exp_q[2].size() != 0) begin
                b = exp_q[2][0];
                chk("t3_stall_data", tx_data_o, b.data);
            end
            tick();
        end
        tx_ready_i = 1'b1;
        wait_idle(40, ic);
        chk("t3_beats", nbeats - nb0, 6);
        chk("t3_none_left", exp_q[2].size(), 0);

        // Wrap-around: port 3 then port 0
        reset_flush();
        load_pkt(3, 3, 1);
        load_pkt(0, 1, 1);
        req_i = 4'b1000;
        wait_grants(1, 10);
        req_i = 4'b1001;
        wait_grants(2, 40);
        req_i = '0;
        wait_idle(30, ic);
        if (glog.size() >= 2) begin
            chk("t4_first", glog[0].port, 3);
            chk("t4_wrap", glog[1].port, 0);
            chk("t4_wrap_gap", glog[1].gap, 3);
        end

        // Reset in the middle of a port-1 packet
        reset_flush();
        load_pkt(1, 4, 1);
        req_i = 4'b0010;
        wait_grants(1, 10);
        req_i = '0;
        tick(); tick();
        reset_flush();
        for (int p = 0; p < 4; p++) load_pkt(p, 1, 1);
        req_i = 4'b1111;
        wait_grants(1, 10);
        req_i = '0;
        wait_idle(20, ic);
        if (glog.size() >= 1) chk("t5_after_reset_port0", glog[0].port, 0);

`ifdef ARB_TIMEOUT_EN
        // Port 1 stops mid-packet: abort after 16 stalled cycles, then port 2
        reset_flush();
        abort_cnt = 0;
        load_pkt(1, 2, 0);
        load_pkt(2, 1, 1);
        req_i = 4'b0110;
        wait_grants(1, 10);
        wait_grants(2, 80);
        req_i = '0;
        wait_idle(20, ic);
        if (glog.size() >= 2) begin
            chk("to_first", glog[0].port, 1);
            chk("to_next", glog[1].port, 2);
        end
        chk("to_abort_pulses", abort_cnt, 1);
        chk("to_abort_port", abort_val, 4'b0010);
        chk("to_abort_delay", abort_gap, 17);
`else
        chk("no_abort", abort_cnt, 0);
`endif

        reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
